// File: rtl/slip_decoder.sv
// slip_decoder: SLIP receive-side framing stage.
// Decodes END/ESC-framed byte streams into a byte stream with an end-of-frame
// marker. Frames with escape errors or more than MAX_LEN decoded bytes are
// closed early and the rest is discarded. Empty frames produce nothing.
// A one-byte hold register delays each decoded byte until the next event, so
// out_last is already known when the byte is pushed to the output register.

module slip_decoder #(
  parameter int MAX_LEN = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       frame_error
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(32'd1);
  localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(32'd0);

  localparam logic [7:0] END_CODE = 8'hC0;
  localparam logic [7:0] ESC_CODE = 8'hDB;
  localparam logic [7:0] ESC_END  = 8'hDC;
  localparam logic [7:0] ESC_ESC  = 8'hDD;

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_ESC     = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  // Decode the byte that follows an ESC: {valid, decoded byte}.
  // Only 0xDC and 0xDD are legal escape operands.
  function automatic logic [8:0] decode_escape(input logic [7:0] code);
    logic [8:0] result;
    case (code)
      ESC_END: result = {1'b1, END_CODE};
      ESC_ESC: result = {1'b1, ESC_CODE};
      default: result = {1'b0, 8'h00};
    endcase
    return result;
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic             hold_valid_r;
  logic             hold_valid_nxt_s;
  logic [7:0]       hold_data_r;
  logic [7:0]       hold_data_nxt_s;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] len_nxt_s;
  logic [7:0]       out_data_r;
  logic             out_valid_r;
  logic             out_last_r;
  logic             frame_error_r;

  logic             accept_s;
  logic             dec_s;       // a decoded data byte is produced this cycle
  logic [7:0]       dec_byte_s;
  logic             close_s;     // END seen: frame ends
  logic             esc_err_s;   // illegal byte after ESC
  logic             ovf_s;       // decoded byte would exceed MAX_LEN
  logic             error_s;
  logic             flush_s;     // close or error: emit held byte as last
  logic             load_s;      // decoded byte goes into hold
  logic             push_s;
  logic [7:0]       push_data_s;
  logic             push_last_s;
  logic [8:0]       esc_dec_s;

  // A byte can only be taken when the output register can absorb a push now.
  assign in_ready    = !out_valid_r || out_ready;
  assign accept_s    = in_valid && in_ready;
  assign out_data    = out_data_r;
  assign out_valid   = out_valid_r;
  assign out_last    = out_last_r;
  assign frame_error = frame_error_r;

  // Decoder state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_NORMAL;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Classify the accepted byte and compute the next decoder state.
  always_comb begin
    state_nxt_s = state_r;
    dec_s       = 1'b0;
    dec_byte_s  = 8'h00;
    close_s     = 1'b0;
    esc_err_s   = 1'b0;
    ovf_s       = 1'b0;
    esc_dec_s   = decode_escape(in_data);
    if (accept_s) begin
      case (state_r)
        ST_NORMAL: begin
          if (in_data == ESC_CODE) begin
            state_nxt_s = ST_ESC;
          end else if (in_data == END_CODE) begin
            close_s = 1'b1;
          end else begin
            dec_s      = 1'b1;
            dec_byte_s = in_data;
          end
        end
        ST_ESC: begin
          if (esc_dec_s[8]) begin
            dec_s       = 1'b1;
            dec_byte_s  = esc_dec_s[7:0];
            state_nxt_s = ST_NORMAL;
          end else if (in_data == END_CODE) begin
            // Truncated escape: report it, but END still ends the frame.
            esc_err_s   = 1'b1;
            close_s     = 1'b1;
            state_nxt_s = ST_NORMAL;
          end else begin
            esc_err_s   = 1'b1;
            state_nxt_s = ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (in_data == END_CODE) begin
            state_nxt_s = ST_NORMAL;
          end else begin
            state_nxt_s = ST_DISCARD;
          end
        end
        default: begin
          state_nxt_s = ST_NORMAL;
        end
      endcase
      // A byte that would be number MAX_LEN+1 is dropped and kills the frame.
      if (dec_s && (len_r == LEN_MAX)) begin
        ovf_s       = 1'b1;
        state_nxt_s = ST_DISCARD;
      end else begin
        ovf_s = 1'b0;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  assign error_s = esc_err_s || ovf_s;
  assign flush_s = close_s || error_s;
  assign load_s  = dec_s && !ovf_s;

  // Hold register, length counter and push generation.
  always_comb begin
    hold_valid_nxt_s = hold_valid_r;
    hold_data_nxt_s  = hold_data_r;
    len_nxt_s        = len_r;
    push_s           = 1'b0;
    push_data_s      = hold_data_r;
    push_last_s      = 1'b0;
    if (flush_s) begin
      // Whatever is held becomes the final byte; empty frames vanish.
      push_s           = hold_valid_r;
      push_last_s      = 1'b1;
      hold_valid_nxt_s = 1'b0;
      len_nxt_s        = LEN_ZERO;
    end else if (load_s) begin
      // A newer byte exists, so the held one is not the last.
      push_s           = hold_valid_r;
      push_last_s      = 1'b0;
      hold_valid_nxt_s = 1'b1;
      hold_data_nxt_s  = dec_byte_s;
      len_nxt_s        = len_r + LEN_ONE;
    end else begin
      push_s = 1'b0;
    end
  end

  // Hold register and length counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid_r <= 1'b0;
      hold_data_r  <= 8'h00;
      len_r        <= LEN_ZERO;
    end else begin
      hold_valid_r <= hold_valid_nxt_s;
      hold_data_r  <= hold_data_nxt_s;
      len_r        <= len_nxt_s;
    end
  end

  // One-entry output register; a push may coincide with a pop without a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
      out_last_r  <= 1'b0;
    end else if (push_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= push_data_s;
      out_last_r  <= push_last_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
      out_data_r  <= out_data_r;
      out_last_r  <= out_last_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
      out_last_r  <= out_last_r;
    end
  end

  // Registered single-cycle error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_error_r <= 1'b0;
    end else begin
      frame_error_r <= error_s;
    end
  end

endmodule
